// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run controller.
// - run_state_t  : FSM state encoding, also driven on the STATE debug output.
// - halt_cause_t : code reported on HALT_CAUSE after every halt.
// - is_busy()    : true in the states where the CPU is allowed to advance.
package cpu_run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RSTW   = 2'd0,
        ST_HALTED = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } run_state_t;

    typedef enum logic [2:0] {
        HC_RESET = 3'd0,
        HC_STOP  = 3'd1,
        HC_BREAK = 3'd2,
        HC_HLT   = 3'd3,
        HC_STEP  = 3'd4
    } halt_cause_t;

    function automatic logic is_busy(input run_state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/cpu_cycle_cnt.sv
// Saturating up-counter used for the executed-instruction count.
// Ports:
//   CLK  in   clock, rising edge
//   RST  in   synchronous active-high clear
//   EN   in   count this cycle
//   CNT  out  current count, holds at all-ones instead of wrapping
module cpu_cycle_cnt #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    output logic [W-1:0] CNT
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            CNT <= '0;
        end else if (EN && (CNT != {W{1'b1}})) begin
            CNT <= CNT + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the one-cycle CPU. The CPU is gated with
// a clock-enable (CPU_EN); this block also owns the CPU reset window, the PC
// breakpoint, HALT-instruction detection and the executed-instruction count.
//
// Request handshake: START, STOP and STEP are single-cycle pulses sampled on
// the rising edge of CLK. There is no back-pressure; a request that is not
// legal in the current state is simply dropped. STEP_N is sampled with STEP.
//
// Ports:
//   CLK, RST    clock / synchronous active-high reset
//   START       resume free run (HALTED only)
//   STOP        halt after the current instruction
//   STEP        run STEP_N instructions then halt (HALTED only); 0 means 1
//   BP_EN       breakpoint enable, BP_ADDR breakpoint PC
//   PC          PC of the instruction about to execute
//   CPU_HLT     CPU decodes a HALT instruction this cycle
//   CPU_EN      CPU clock-enable (combinational from state and PC)
//   CPU_RST     CPU reset (registered)
//   BUSY        high in RUN or STEPPING
//   STATE       FSM state (run_state_t encoding)
//   HALT_CAUSE  reason for the most recent halt (halt_cause_t)
//   CYC_CNT     instructions executed, saturating
//   DONE        one-cycle pulse on every RUN/STEPPING -> HALTED transition
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int PC_W       = 8,
    parameter int CNT_W      = 32,
    parameter int STEP_W     = 8,
    parameter int RST_CYCLES = 2,
    parameter int AUTO_RUN   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              STOP,
    input  logic              STEP,
    input  logic [STEP_W-1:0] STEP_N,
    input  logic              BP_EN,
    input  logic [PC_W-1:0]   BP_ADDR,
    input  logic [PC_W-1:0]   PC,
    input  logic              CPU_HLT,
    output logic              CPU_EN,
    output logic              CPU_RST,
    output logic              BUSY,
    output logic [1:0]        STATE,
    output logic [2:0]        HALT_CAUSE,
    output logic [CNT_W-1:0]  CYC_CNT,
    output logic              DONE
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t        state;
    halt_cause_t       cause;
    logic [RC_W-1:0]   rst_cnt;
    logic [STEP_W-1:0] rem;
    logic              bp_skip;
    logic              busy_q;
    logic              done_q;
    logic              cpu_rst_q;

    logic              bp_hit;
    logic              cpu_en;
    logic              halt_req;
    halt_cause_t       halt_code;

    // bp_skip masks the breakpoint for the first executed instruction after
    // resuming from a BREAK halt, so the instruction at BP_ADDR can run.
    assign bp_hit = BP_EN && (PC == BP_ADDR) && !bp_skip;
    assign cpu_en = is_busy(state) && !bp_hit;

    // Halt decision while busy, highest priority first. A breakpoint wins over
    // everything because that instruction never executes this cycle.
    always_comb begin
        halt_req  = 1'b0;
        halt_code = HC_RESET;
        if (is_busy(state)) begin
            if (bp_hit) begin
                halt_req  = 1'b1;
                halt_code = HC_BREAK;
            end else if (cpu_en && CPU_HLT) begin
                halt_req  = 1'b1;
                halt_code = HC_HLT;
            end else if ((state == ST_STEP) && cpu_en && (rem == STEP_W'(1))) begin
                halt_req  = 1'b1;
                halt_code = HC_STEP;
            end else if (STOP) begin
                halt_req  = 1'b1;
                halt_code = HC_STOP;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_RSTW;
            cause     <= HC_RESET;
            rst_cnt   <= '0;
            rem       <= '0;
            bp_skip   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_RSTW: begin
                    // rst_cnt counts RST-low edges; the last one releases CPU_RST.
                    if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
                        cpu_rst_q <= 1'b0;
                        cause     <= HC_RESET;
                        if (AUTO_RUN != 0) begin
                            state  <= ST_RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= ST_HALTED;
                        end
                    end else begin
                        rst_cnt <= rst_cnt + RC_W'(1);
                    end
                end
                ST_HALTED: begin
                    // STOP beats STEP beats START; STOP alone does nothing here.
                    if (!STOP && (STEP || START)) begin
                        busy_q <= 1'b1;
                        if (cause == HC_BREAK) begin
                            bp_skip <= 1'b1;
                        end
                        if (STEP) begin
                            state <= ST_STEP;
                            rem   <= (STEP_N == '0) ? STEP_W'(1) : STEP_N;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    if (cpu_en) begin
                        bp_skip <= 1'b0;
                    end
                    if (halt_req) begin
                        state  <= ST_HALTED;
                        cause  <= halt_code;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        rem    <= '0;
                    end else if ((state == ST_STEP) && cpu_en) begin
                        rem <= rem - STEP_W'(1);
                    end
                end
            endcase
        end
    end

    cpu_cycle_cnt #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .CLK (CLK),
        .RST (RST),
        .EN  (cpu_en),
        .CNT (CYC_CNT)
    );

    assign CPU_EN     = cpu_en;
    assign CPU_RST    = cpu_rst_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign STATE      = state;
    assign HALT_CAUSE = cause;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl. A second instance with a 4-bit counter shares all
// inputs to exercise counter saturation. The bench plays the CPU: when
// pc_follow is set, PC advances after every cycle with CPU_EN=1.
module tb_cpu_run_ctrl;

    localparam int PC_W       = 8;
    localparam int CNT_W      = 32;
    localparam int STEP_W     = 8;
    localparam int RST_CYCLES = 2;

    // ---------------- clock / reset / DUT ----------------
    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              START = 1'b0;
    logic              STOP = 1'b0;
    logic              STEP = 1'b0;
    logic [STEP_W-1:0] STEP_N = '0;
    logic              BP_EN = 1'b0;
    logic [PC_W-1:0]   BP_ADDR = '0;
    logic [PC_W-1:0]   PC = '0;
    logic              CPU_HLT = 1'b0;

    logic              CPU_EN, CPU_RST, BUSY, DONE;
    logic [1:0]        STATE;
    logic [2:0]        HALT_CAUSE;
    logic [CNT_W-1:0]  CYC_CNT;

    logic              s_en, s_rst, s_busy, s_done;
    logic [1:0]        s_state;
    logic [2:0]        s_cause;
    logic [3:0]        s_cnt;

    always #5 CLK = ~CLK;

    cpu_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .STEP_W(STEP_W), .RST_CYCLES(RST_CYCLES), .AUTO_RUN(0)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .STEP(STEP), .STEP_N(STEP_N),
        .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .PC(PC), .CPU_HLT(CPU_HLT),
        .CPU_EN(CPU_EN), .CPU_RST(CPU_RST), .BUSY(BUSY), .STATE(STATE),
        .HALT_CAUSE(HALT_CAUSE), .CYC_CNT(CYC_CNT), .DONE(DONE)
    );

    cpu_run_ctrl #(
        .PC_W(PC_W), .CNT_W(4), .STEP_W(STEP_W), .RST_CYCLES(RST_CYCLES), .AUTO_RUN(0)
    ) dut_small (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .STEP(STEP), .STEP_N(STEP_N),
        .BP_EN(BP_EN), .BP_ADDR(BP_ADDR), .PC(PC), .CPU_HLT(CPU_HLT),
        .CPU_EN(s_en), .CPU_RST(s_rst), .BUSY(s_busy), .STATE(s_state),
        .HALT_CAUSE(s_cause), .CYC_CNT(s_cnt), .DONE(s_done)
    );

    int checks = 0;
    int errors = 0;
    bit pc_follow = 1'b0;
    bit last_en = 1'b0;

    // ---------------- reference model ----------------
    // mode: 0 reset window, 1 halted, 2 free run, 3 stepping
    int     m_mode = 0;
    int     m_rst_seen = 0;
    int     m_rem = 0;
    bit     m_skip = 1'b0;
    int     m_cause = 0;
    longint m_cnt = 0;
    bit     m_done = 1'b0;
    bit     m_cpu_rst = 1'b1;

    function automatic bit m_bp_hit();
        return BP_EN && (PC == BP_ADDR) && !m_skip;
    endfunction

    function automatic bit m_en();
        return (m_mode >= 2) && !m_bp_hit();
    endfunction

    function automatic void model_edge();
        bit hit;
        bit en;
        int code;
        hit  = m_bp_hit();
        en   = m_en();
        code = -1;
        if (RST) begin
            m_mode = 0; m_rst_seen = 0; m_rem = 0; m_skip = 1'b0;
            m_cause = 0; m_cnt = 0; m_done = 1'b0; m_cpu_rst = 1'b1;
            return;
        end
        m_done = 1'b0;
        if (en) m_cnt++;
        if (m_mode == 0) begin
            m_rst_seen++;
            if (m_rst_seen == RST_CYCLES) begin
                m_cpu_rst = 1'b0;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (!STOP && (START || STEP)) begin
                if (m_cause == 2) m_skip = 1'b1;
                if (STEP) begin
                    m_mode = 3;
                    m_rem = (STEP_N == 0) ? 1 : int'(STEP_N);
                end else begin
                    m_mode = 2;
                end
            end
        end else begin
            if (en) m_skip = 1'b0;
            if (hit)                             code = 2;
            else if (en && CPU_HLT)              code = 3;
            else if (m_mode == 3 && en && m_rem == 1) code = 4;
            else if (STOP)                       code = 1;
            if (code >= 0) begin
                m_mode = 1; m_cause = code; m_done = 1'b1;
            end else if (m_mode == 3 && en) begin
                m_rem--;
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    // Called 2 time units after a rising edge; samples 3 units later, updates
    // the model with the inputs the DUT is about to see, then crosses the edge.
    task automatic tick();
        bit en_now;
        #3;
        en_now = CPU_EN;
        last_en = en_now;
        model_edge();
        @(posedge CLK);
        #1;
        if (pc_follow && en_now) PC = PC + PC_W'(1);
        #1;
    endtask

    task automatic do_reset();
        START = 0; STOP = 0; STEP = 0; CPU_HLT = 0; BP_EN = 0;
        RST = 1; tick(); RST = 0;
        repeat (RST_CYCLES) tick();
    endtask

    task automatic pulse_start();
        START = 1; tick(); START = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int hi_cycles;
        bit done_seen;
        RST = 1; tick();
        checks++; if (STATE !== 2'd0) begin errors++; $display("FAIL reset.state got %0d exp 0", STATE); end
        checks++; if (CPU_RST !== 1'b1) begin errors++; $display("FAIL reset.cpu_rst got %b exp 1", CPU_RST); end
        checks++; if (CPU_EN !== 1'b0) begin errors++; $display("FAIL reset.cpu_en got %b exp 0", CPU_EN); end
        checks++; if (CYC_CNT !== '0) begin errors++; $display("FAIL reset.cyc_cnt got %0d exp 0", CYC_CNT); end
        checks++; if (DONE !== 1'b0 || BUSY !== 1'b0) begin errors++; $display("FAIL reset.done_busy got %b%b exp 00", DONE, BUSY); end
        RST = 0;
        hi_cycles = 1;
        done_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DONE) done_seen = 1'b1;
            if (CPU_RST === 1'b1) hi_cycles++; else break;
        end
        checks++; if (hi_cycles != RST_CYCLES) begin errors++; $display("FAIL reset.window got %0d exp %0d", hi_cycles, RST_CYCLES); end
        repeat (3) begin tick(); if (DONE) done_seen = 1'b1; end
        checks++; if (STATE !== 2'd1) begin errors++; $display("FAIL reset.halted got %0d exp 1", STATE); end
        checks++; if (CPU_EN !== 1'b0 || HALT_CAUSE !== 3'd0) begin errors++; $display("FAIL reset.idle en %b cause %0d exp 0 0", CPU_EN, HALT_CAUSE); end
        checks++; if (done_seen) begin errors++; $display("FAIL reset.no_done got 1 exp 0"); end
    endtask

    task automatic test_step(input int n, input int exp_en, input int exp_cnt);
        int en_cnt;
        bit got_done;
        en_cnt = 0; got_done = 1'b0;
        STEP_N = STEP_W'(n); STEP = 1; tick(); STEP = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last_en) en_cnt++;
            if (DONE) begin got_done = 1'b1; break; end
        end
        checks++; if (!got_done) begin errors++; $display("FAIL step%0d.timeout got no DONE exp DONE", n); end
        checks++; if (en_cnt != exp_en) begin errors++; $display("FAIL step%0d.en_cycles got %0d exp %0d", n, en_cnt, exp_en); end
        checks++; if (CYC_CNT !== CNT_W'(exp_cnt)) begin errors++; $display("FAIL step%0d.cyc_cnt got %0d exp %0d", n, CYC_CNT, exp_cnt); end
        checks++; if (HALT_CAUSE !== 3'd4 || STATE !== 2'd1) begin errors++; $display("FAIL step%0d.cause got %0d/%0d exp 4/1", n, HALT_CAUSE, STATE); end
        tick();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL step%0d.done_width got %b exp 0", n, DONE); end
    endtask

    task automatic test_breakpoint();
        int en_cnt;
        do_reset();
        PC = '0; pc_follow = 1; BP_EN = 1; BP_ADDR = 8'h05;
        pulse_start();
        en_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (last_en) en_cnt++;
            if (DONE) break;
        end
        checks++; if (en_cnt != 5 || CYC_CNT !== CNT_W'(5)) begin errors++; $display("FAIL bp.run en %0d cnt %0d exp 5 5", en_cnt, CYC_CNT); end
        checks++; if (HALT_CAUSE !== 3'd2) begin errors++; $display("FAIL bp.cause got %0d exp 2", HALT_CAUSE); end
        checks++; if (PC !== 8'h05 || CPU_EN !== 1'b0) begin errors++; $display("FAIL bp.stop_pc pc %0d en %b exp 5 0", PC, CPU_EN); end
        STEP_N = 8'd1; STEP = 1; tick(); STEP = 0;
        en_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (last_en) en_cnt++;
            if (DONE) break;
        end
        checks++; if (en_cnt != 1 || CYC_CNT !== CNT_W'(6)) begin errors++; $display("FAIL bp.resume en %0d cnt %0d exp 1 6", en_cnt, CYC_CNT); end
        checks++; if (PC !== 8'h06 || HALT_CAUSE !== 3'd4) begin errors++; $display("FAIL bp.resume_pc pc %0d cause %0d exp 6 4", PC, HALT_CAUSE); end
        BP_EN = 0; pc_follow = 0;
    endtask

    task automatic test_hlt_stop();
        do_reset();
        pulse_start();
        repeat (3) tick();
        CPU_HLT = 1; STOP = 1; tick(); CPU_HLT = 0; STOP = 0;
        checks++; if (HALT_CAUSE !== 3'd3) begin errors++; $display("FAIL hlt.cause got %0d exp 3", HALT_CAUSE); end
        checks++; if (CYC_CNT !== CNT_W'(4)) begin errors++; $display("FAIL hlt.counted got %0d exp 4", CYC_CNT); end
        checks++; if (DONE !== 1'b1 || STATE !== 2'd1 || CPU_EN !== 1'b0) begin errors++; $display("FAIL hlt.halt done %b state %0d en %b exp 1 1 0", DONE, STATE, CPU_EN); end
        tick();
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL hlt.done_width got %b exp 0", DONE); end
    endtask

    task automatic test_rst_midrun();
        do_reset();
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (CYC_CNT == CNT_W'(40)) break;
            tick();
        end
        checks++; if (CYC_CNT !== CNT_W'(40) || STATE !== 2'd2) begin errors++; $display("FAIL midrst.pre cnt %0d state %0d exp 40 2", CYC_CNT, STATE); end
        RST = 1; tick();
        checks++; if (CPU_EN !== 1'b0 || CPU_RST !== 1'b1) begin errors++; $display("FAIL midrst.cpu en %b rst %b exp 0 1", CPU_EN, CPU_RST); end
        checks++; if (CYC_CNT !== '0 || STATE !== 2'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL midrst.regs cnt %0d state %0d busy %b exp 0 0 0", CYC_CNT, STATE, BUSY); end
        RST = 0;
        repeat (RST_CYCLES) tick();
    endtask

    task automatic test_saturate_ignore();
        do_reset();
        pulse_start();
        repeat (20) tick();
        checks++; if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat.small got %0d exp 15", s_cnt); end
        checks++; if (CYC_CNT !== CNT_W'(20)) begin errors++; $display("FAIL sat.wide got %0d exp 20", CYC_CNT); end
        pulse_start();
        checks++; if (STATE !== 2'd2 || BUSY !== 1'b1) begin errors++; $display("FAIL ignore.start state %0d busy %b exp 2 1", STATE, BUSY); end
        STEP_N = 8'd2; STEP = 1; tick(); STEP = 0;
        checks++; if (STATE !== 2'd2 || CYC_CNT !== CNT_W'(22)) begin errors++; $display("FAIL ignore.step state %0d cnt %0d exp 2 22", STATE, CYC_CNT); end
        STOP = 1; tick(); STOP = 0;
        checks++; if (HALT_CAUSE !== 3'd1 || DONE !== 1'b1 || CYC_CNT !== CNT_W'(23)) begin errors++; $display("FAIL stop.run cause %0d done %b cnt %0d exp 1 1 23", HALT_CAUSE, DONE, CYC_CNT); end
    endtask

    task automatic test_random();
        logic [3:0] exp_small;
        do_reset();
        pc_follow = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            RST     = ($urandom_range(0, 99) == 0);
            START   = ($urandom_range(0, 7) == 0);
            STOP    = ($urandom_range(0, 11) == 0);
            STEP    = ($urandom_range(0, 7) == 0);
            STEP_N  = STEP_W'($urandom_range(0, 5));
            CPU_HLT = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) BP_EN = ~BP_EN;
            if ($urandom_range(0, 31) == 0) BP_ADDR = PC_W'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) PC = PC_W'($urandom_range(0, 15));
            tick();
            exp_small = (m_cnt > 15) ? 4'd15 : 4'(m_cnt);
            checks++; if (STATE !== 2'(m_mode) || s_state !== 2'(m_mode)) begin errors++; $display("FAIL rand.state cyc %0d got %0d/%0d exp %0d", cyc, STATE, s_state, m_mode); end
            checks++; if (CPU_EN !== m_en()) begin errors++; $display("FAIL rand.cpu_en cyc %0d got %b exp %b", cyc, CPU_EN, m_en()); end
            checks++; if (CPU_RST !== m_cpu_rst) begin errors++; $display("FAIL rand.cpu_rst cyc %0d got %b exp %b", cyc, CPU_RST, m_cpu_rst); end
            checks++; if (BUSY !== (m_mode >= 2)) begin errors++; $display("FAIL rand.busy cyc %0d got %b exp %b", cyc, BUSY, (m_mode >= 2)); end
            checks++; if (HALT_CAUSE !== 3'(m_cause)) begin errors++; $display("FAIL rand.cause cyc %0d got %0d exp %0d", cyc, HALT_CAUSE, m_cause); end
            checks++; if (DONE !== m_done) begin errors++; $display("FAIL rand.done cyc %0d got %b exp %b", cyc, DONE, m_done); end
            checks++; if (CYC_CNT !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rand.cyc_cnt cyc %0d got %0d exp %0d", cyc, CYC_CNT, m_cnt); end
            checks++; if (s_cnt !== exp_small) begin errors++; $display("FAIL rand.sat_cnt cyc %0d got %0d exp %0d", cyc, s_cnt, exp_small); end
        end
        RST = 0; START = 0; STOP = 0; STEP = 0; CPU_HLT = 0; BP_EN = 0;
        pc_follow = 0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_step(3, 3, 3);
        test_step(0, 1, 4);
        test_breakpoint();
        test_hlt_stop();
        test_rst_midrun();
        test_saturate_ignore();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no end of test exp end before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
